i2s_mic_rx: RTL
===============

# i2s_mic_rx

Parametrised I2S microphone receiver. It generates the bit clock (`sck`) and word select (`ws`) from the system clock and captures left and right samples of configurable width from a serial MEMS microphone. Each completed sample is presented on a valid/ready stream tagged with its channel. It sits between the board microphone pins and the audio FIFO/PCM path, replacing the fixed 6-bit, single-channel capture.

## Interface
- `CLK_DIV`, 16: `clk` cycles per `sck` half-period (≥2).
- `SLOT_W`, 32: `sck` periods per channel slot; frame = 2·`SLOT_W`.
- `SAMPLE_W`, 18: bits captured per sample, MSB first; must satisfy 1 ≤ `SAMPLE_W` ≤ `SLOT_W`-1.
- `WARMUP_FRAMES`, 2: frames discarded after enable (mic start-up).
- `FIFO_DEPTH`, 4: output FIFO entries, power of 2; used only with `I2S_MIC_FIFO_EN`.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: run enable; low forces IDLE.
- `sck` out 1: I2S bit clock to mic.
- `ws` out 1: word select; 0 = left, 1 = right.
- `sd` in 1: serial data from mic.
- `sample_data` out `SAMPLE_W`: captured sample, two's complement.
- `sample_ch` out 1: channel of `sample_data` (0 L, 1 R).
- `sample_valid` out 1: output holds a sample.
- `sample_ready` in 1: consumer accepts when valid&ready.
- `overrun` out 1: sticky, a sample was dropped.

## Operation
- Reset values: `sck`=0, `ws`=0, `sample_data`=0, `sample_ch`=0, `sample_valid`=0, `overrun`=0, state IDLE, all counters 0, FIFO empty.
- Divider `div_cnt` 0..`CLK_DIV`-1; at terminal count `sck` toggles. rise_tick = terminal count with `sck`=0; fall_tick = terminal count with `sck`=1.
- `bit_cnt` 0..2·`SLOT_W`-1 advances on each fall_tick and wraps to 0. `ws` is registered as (`bit_cnt` ≥ `SLOT_W`), so it changes at the falling edge of `sck`. Slot index s = `bit_cnt` mod `SLOT_W`.
- I2S one-bit delay: on rise_tick with 1 ≤ s ≤ `SAMPLE_W`, `sd` shifts into the shift register LSB-side. Bits at s=0 and at s>`SAMPLE_W` are ignored.
- On the rise_tick with s=`SAMPLE_W`, the word is complete. On the next `clk` edge it is pushed with channel = `ws`.
- FSM states:
  - IDLE: `sck`/`ws` held 0, counters cleared. Leaves to WARM when `en`=1, and at that transition `overrun` clears.
  - WARM: clocks run, completed words are not pushed. Moves to RUN after `WARMUP_FRAMES` wraps of `bit_cnt`; with `WARMUP_FRAMES`=0 it goes directly to RUN.
  - RUN: words are pushed.
- `en`=0 in any state: next cycle returns to IDLE. A partial sample is discarded. Already-pushed output is kept and remains consumable.
- Push when the output is full (`sample_valid`=1 and no pop in that cycle) drops the new word and sets `overrun`. Push and pop in the same cycle succeed.

## Timing
- `sck` period = 2·`CLK_DIV` `clk`; frame = 2·`SLOT_W`·2·`CLK_DIV` `clk`. Defaults at 50 MHz: `sck` 1.5625 MHz, fs ≈ 24.4 kHz.
- First `sck` rising edge occurs `CLK_DIV` cycles after IDLE→WARM.
- Latency: `sample_valid` rises 1 `clk` after the clock edge of the completing rise_tick.
- `sample_data`/`sample_ch` are stable while `sample_valid`=1 and `sample_ready`=0. On a pop, the next entry (if any) appears the following cycle, so back-to-back pops are possible.

## Configuration
- `I2S_MIC_FIFO_EN` defined: show-ahead FIFO of `FIFO_DEPTH` entries of {ch, data}. Outputs show the head entry. Overrun occurs only when the FIFO is full.
- Not defined: single output register (depth 1). `FIFO_DEPTH` is ignored.

## Test plan
- Reset: `reset`=0 mid-frame → all outputs 0 immediately; after release with `en`=0, `sck` stays 0.
- Capture: `CLK_DIV`=2, `SLOT_W`=32, `SAMPLE_W`=18, `WARMUP_FRAMES`=0. Mic model drives L=18'h2A5A5, R=18'h15A5A with bits after LSB = 1 → stream yields (ch0, 18'h2A5A5) then (ch1, 18'h15A5A), repeating every 256 `clk`.
- Warm-up: `WARMUP_FRAMES`=2 → first `sample_valid` only after 2 full frames (2·256 `clk` at `CLK_DIV`=2) plus the L completion time.
- Overrun: `sample_ready`=0 → without FIFO, 1 sample held and `overrun`=1 at the 2nd completion. With FIFO (depth 4), 4 held and `overrun`=1 at the 5th; the held data equals the first samples.
- Backpressure: random `sample_ready` at ≥50 % duty → no loss, `overrun`=0, order preserved.
- Enable drop: `en`=0 at s=9 of the left slot → no push of the partial sample, IDLE next cycle, `sck`=`ws`=0. Re-enable → `overrun` clears and warm-up restarts.

Source files
------------

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S MEMS microphone receiver.
// Generates sck/ws from clk, captures left/right samples (MSB first, one-bit
// I2S delay) and presents them on a valid/ready stream tagged with channel.
// Optional feature macro: I2S_MIC_FIFO_EN selects a FIFO_DEPTH-entry
// show-ahead output FIFO; without it the output is a single register.
// i_reset is asynchronous and active-low.
module i2s_mic_rx #(
    parameter int CLK_DIV       = 16,
    parameter int SLOT_W        = 32,
    parameter int SAMPLE_W      = 18,
    parameter int WARMUP_FRAMES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    output logic                o_sck,
    output logic                o_ws,
    input  logic                i_sd,
    output logic [SAMPLE_W-1:0] o_sample_data,
    output logic                o_sample_ch,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    output logic                o_overrun
);

    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int WARM_W     = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_sck;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_ws;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [SAMPLE_W-1:0] r_shift;
    logic                r_word_rdy;
    logic                r_overrun;

    logic                w_run;
    logic                w_tc;
    logic                w_rise;
    logic                w_fall;
    logic                w_wrap;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [BIT_W-1:0]    w_slot;
    logic                w_capture;
    logic                w_complete;
    logic                w_clr_ovr;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_drop;

    // Clocks run only while enabled outside IDLE; dropping en freezes and clears them.
    assign w_run      = (r_state != ST_IDLE) && i_en;
    assign w_tc       = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_rise     = w_run && w_tc && !r_sck;
    assign w_fall     = w_run && w_tc &&  r_sck;
    assign w_wrap     = w_fall && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign w_bit_nxt  = w_wrap ? '0 : r_bit_cnt + 1'b1;
    assign w_slot     = (r_bit_cnt >= BIT_W'(SLOT_W)) ? r_bit_cnt - BIT_W'(SLOT_W) : r_bit_cnt;
    // Slot bit 0 is the I2S delay bit; data occupies slot bits 1..SAMPLE_W.
    assign w_capture  = w_rise && (w_slot >= BIT_W'(1)) && (w_slot <= BIT_W'(SAMPLE_W));
    assign w_complete = w_rise && (w_slot == BIT_W'(SAMPLE_W)) && (r_state == ST_RUN);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: en low always wins; IDLE exit clears the sticky overrun.
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_clr_ovr   = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARM;
                    w_clr_ovr   = 1'b1;
                end
                ST_WARM: if (w_wrap && (r_warm_cnt == WARM_LAST)) w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // sck divider, frame bit counter, ws (updated on the sck falling edge) and warm-up count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_div_cnt  <= '0;
            r_sck      <= 1'b0;
            r_bit_cnt  <= '0;
            r_ws       <= 1'b0;
            r_warm_cnt <= '0;
        end else if (!w_run) begin
            r_div_cnt  <= '0;
            r_sck      <= 1'b0;
            r_bit_cnt  <= '0;
            r_ws       <= 1'b0;
            r_warm_cnt <= '0;
        end else begin
            r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
            if (w_tc) r_sck <= ~r_sck;
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_ws      <= (w_bit_nxt >= BIT_W'(SLOT_W));
            end
            if ((r_state == ST_WARM) && w_wrap) r_warm_cnt <= r_warm_cnt + 1'b1;
        end
    end

    // Serial capture; a completed word is flagged for push on the following edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift    <= '0;
            r_word_rdy <= 1'b0;
        end else begin
            r_word_rdy <= w_complete;
            if (!w_run)         r_shift <= '0;
            else if (w_capture) r_shift <= (r_shift << 1) | SAMPLE_W'(i_sd);
        end
    end

    assign w_push = r_word_rdy;
    assign w_drop = w_push && w_full;

`ifdef I2S_MIC_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [SAMPLE_W:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_wr;

    assign w_pop  = (r_count != '0) && i_sample_ready;
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH)) && !w_pop;
    assign w_wr   = w_push && !w_full;

    // FIFO storage write port.
    // NOTE: storage has no reset; outputs are gated by r_count so stale entries never show.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_ws, r_shift};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_sample_valid               = (r_count != '0);
    assign {o_sample_ch, o_sample_data} = o_sample_valid ? r_mem[r_rd_ptr] : '0;
`else
    logic [SAMPLE_W-1:0] r_out_data;
    logic                r_out_ch;
    logic                r_out_valid;

    assign w_pop  = r_out_valid && i_sample_ready;
    assign w_full = r_out_valid && !w_pop;

    // Single output register: load on push when free (or popped this cycle).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_data  <= '0;
            r_out_ch    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_push && !w_full) begin
            r_out_data  <= r_shift;
            r_out_ch    <= r_ws;
            r_out_valid <= 1'b1;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_sample_valid = r_out_valid;
    assign o_sample_data  = r_out_data;
    assign o_sample_ch    = r_out_ch;
`endif

    // Sticky overrun: set on a dropped word, cleared when leaving IDLE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)       r_overrun <= 1'b0;
        else if (w_clr_ovr) r_overrun <= 1'b0;
        else if (w_drop)    r_overrun <= 1'b1;
    end

    assign o_sck     = r_sck;
    assign o_ws      = r_ws;
    assign o_overrun = r_overrun;

endmodule
